token_streamer: RTL

TOKEN_STREAMER -- requirements
Module: token_streamer

---
 rtl/calc_pkg.sv | 20 ++
 rtl/token_streamer.sv | 116 +++++++++++
 2 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: default sizes, the streamer
// state encoding and the address-width helper.
package calc_pkg;

    localparam int DEFAULT_DEPTH = 20;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        FIN   = 2'd3
    } state_t;

    // ceil(log2(n)), never narrower than one bit so a degenerate size still elaborates.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/token_streamer.sv
// Streams the first min(count, depth) buffer entries out over a valid/ready
// port, one token per fetch/send pair, and pulses done when the readout ends.
module token_streamer
    import calc_pkg::*;
#(
    parameter int depth = DEFAULT_DEPTH,
    parameter int width = DEFAULT_WIDTH,
    localparam int AW = addr_width(depth),
    localparam int CW = addr_width(depth + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [AW-1:0]    rdAddr,
    input  logic [width-1:0] rdData,
    output logic [width-1:0] tokOut,
    output logic             tokValid,
    input  logic             tokReady,
    output logic             tokLast,
    output logic             busy,
    output logic             done
);

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      len_q, len_d;
    logic [width-1:0]   tok_out_q, tok_out_d;
    logic               tok_valid_q, tok_valid_d;
    logic               tok_last_q, tok_last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CW-1:0]      count_clamped;

    assign count_clamped = (count > CW'(depth)) ? CW'(depth) : count;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        tok_out_d   = tok_out_q;
        tok_valid_d = tok_valid_q;
        tok_last_d  = tok_last_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = count_clamped;
                    idx_d   = '0;
                    state_d = (count_clamped == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                tok_out_d   = rdData;
                tok_valid_d = 1'b1;
                tok_last_d  = (CW'(idx_q) == len_q - CW'(1));
                state_d     = SEND;
            end
            SEND: begin
                if (tok_valid_q && tokReady) begin
                    tok_valid_d = 1'b0;
                    tok_last_d  = 1'b0;
                    if (tok_last_q) begin
                        // done rises together with FIN so it lands right after the last handshake.
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            FIN: begin
                // An empty readout enters FIN without done, so it fires here instead.
                done_d  = ~done_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over everything.
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            tok_out_q   <= '0;
            tok_valid_q <= 1'b0;
            tok_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            tok_out_q   <= tok_out_d;
            tok_valid_q <= tok_valid_d;
            tok_last_q  <= tok_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rdAddr   = idx_q;
    assign tokOut   = tok_out_q;
    assign tokValid = tok_valid_q;
    assign tokLast  = tok_last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
